muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer for the EX stage. It accepts operand pairs (out_A/out_B of the ALU operand-select stage) with a MIPS mult/multu/div/divu opcode and runs a radix-2 shift-add or restoring-divide loop over WIDTH cycles. It owns the architectural HI/LO registers and raises a stall request so the pipeline holds dependent mfhi/mflo. Supports mthi/mtlo writes and pipeline flush.

Parameters:
WIDTH, 32, operand and HI/LO width; must be a power of two ≥ 8.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request to begin an operation; sampled only in IDLE
op  in  2  operation: 0 mult, 1 multu, 2 div, 3 divu
src_a  in  WIDTH  multiplicand / dividend
src_b  in  WIDTH  multiplier / divisor
flush  in  1  abort any in-flight operation
hi_we  in  1  mthi write enable
lo_we  in  1  mtlo write enable
wdata  in  WIDTH  mthi/mtlo data
busy  out  1  registered; high while state ≠ IDLE
stall_req  out  1  combinational: busy | (start & ~flush)
done  out  1  one-cycle pulse when HI/LO receive a result
div_by_zero  out  1  one-cycle pulse coincident with done for div/divu with src_b = 0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE, counter 0, busy 0, done 0, div_by_zero 0, hi 0, lo 0; internal operand registers 0. Reset mid-operation discards it without a done pulse.
- States: IDLE → CALC → FIX → IDLE.
- IDLE: start & ~flush latches |src_a|, |src_b| (signed ops), or raw values (unsigned ops). Latches op, the result-sign bits, and divisor-zero. Next state CALC, counter 0.
- CALC: exactly WIDTH iterations, one per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After iteration WIDTH-1 → FIX.
- FIX: apply sign. Negate the product if the operand signs differ. Negate the quotient if the dividend and divisor signs differ; give the remainder the dividend's sign. Write HI/LO; assert done for the following cycle; → IDLE.
- Timing: start sampled at edge k → busy high cycles k+1..k+WIDTH+1. Result is visible on hi/lo and done=1 in the cycle after edge k+WIDTH+1 (WIDTH+2 edges total; 34 for WIDTH=32). busy is low in the done cycle.
- Result mapping:
  - mult/multu: HI = upper half, LO = lower half.
  - div/divu: LO = quotient, HI = remainder.
  - Truncation is toward zero.
- Divide by zero: full latency, LO = all ones, HI = dividend (unmodified src_a), div_by_zero pulses with done.
- Signed overflow (most-negative / −1): LO = most-negative value, HI = 0, no flag.
- start while busy: ignored; no queueing.
- flush: while busy, returns to IDLE next edge with HI/LO unchanged and no done. In IDLE, flush and start together: flush wins, nothing starts.
- hi_we/lo_we:
  - Honored only in IDLE when start is not simultaneously accepted. HI/LO update at the next edge.
  - If start is accepted in the same cycle, the write is dropped.
  - While busy they are ignored; upstream must stall on stall_req.
- done and div_by_zero are never asserted together with busy.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3);
  - state encoding (ST_IDLE, ST_CALC, ST_FIX);
  - counter width as $clog2(WIDTH)+1.
- One natural sub-module: muldiv_step, a combinational single radix-2 iteration (shift-add for multiply, trial-subtract for divide). The sequencer, sign handling and HI/LO stay in muldiv_ctrl.

Test Plan:
- Reset, then mult src_a=7, src_b=0xFFFFFFFD (−3) → after 34 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- multu 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- div 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- divu 100 / 0 → done with div_by_zero=1, lo=0xFFFFFFFF, hi=0x00000064.
- mthi 0x1234 then mtlo 0x5678; start mult 3×4; flush asserted 10 cycles in → no done, busy=0 next cycle, hi=0x1234, lo=0x5678. A second start while busy is ignored.
- rst asserted mid-CALC → next cycle busy=0, hi=lo=0, no done. start+flush in the same IDLE cycle → busy stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Iteration counter width for a given operand width.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    fits   = rem_sh >= {1'b0, opnd};
    // The difference is below the divisor whenever it is kept, so WIDTH bits suffice.
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) acc_next = {(fits ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], fits};
    else        acc_next = {sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative mult/div sequencer owning HI/LO; magnitudes are iterated, signs applied in FIX.
//   state   | meaning
//   ST_IDLE | waiting for start; mthi/mtlo accepted here
//   ST_CALC | WIDTH radix-2 iterations on the magnitude accumulator
//   ST_FIX  | sign correction and HI/LO write
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   opnd, abs_a, abs_b, quo_fix, rem_fix;
  logic               op_div, neg_res, neg_rem, div_zero;
  logic               accept, is_signed, last_iter;

  assign is_signed = ~op[0];
  assign accept    = (state == ST_IDLE) & start & ~flush;
  assign last_iter = cnt == CW'(WIDTH - 1);
  assign abs_a     = (is_signed & src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b     = (is_signed & src_b[WIDTH-1]) ? -src_b : src_b;
  assign busy      = state != ST_IDLE;
  assign stall_req = busy | (start & ~flush);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = ST_CALC;
      ST_CALC: begin
        if (flush)          state_next = ST_IDLE;
        else if (last_iter) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Divide by zero leaves the dividend magnitude in the remainder, so HI
  // regains the original src_a after sign fix; only LO needs an override.
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      op_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      div_zero    <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            op_div   <= op[1];
            neg_res  <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem  <= is_signed & src_a[WIDTH-1];
            div_zero <= op[1] & (src_b == '0);
            if (op[1]) begin
              acc  <= {{WIDTH{1'b0}}, abs_a};
              opnd <= abs_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, abs_b};
              opnd <= abs_a;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        ST_CALC: begin
          if (!flush) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
          end
        end
        ST_FIX: begin
          if (!flush) begin
            done        <= 1'b1;
            div_by_zero <= div_zero;
            if (op_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: cycle-level arithmetic model plus literal result checks.
module tb_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b, wdata;
  logic         busy, stall_req, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Model state: cycles left busy, pending result, visible HI/LO and pulses.
  int           m_left;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         p_dbz, m_done, m_dbz;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .stall_req   (stall_req),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] p;
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == '0) begin
          l = '1; h = a; z = 1'b1;
        end else if (o == 2'd2) begin
          l = 32'(sa / sb); h = 32'(sa % sb);
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] th, tl;
    logic         tz;
    m_done <= 1'b0;
    m_dbz  <= 1'b0;
    if (rst) begin
      m_left <= 0; m_hi <= '0; m_lo <= '0;
    end else if (m_left == 0) begin
      if (start && !flush) begin
        model(op, src_a, src_b, th, tl, tz);
        p_hi <= th; p_lo <= tl; p_dbz <= tz;
        m_left <= W + 1;
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
      end
    end else if (flush) begin
      m_left <= 0;
    end else if (m_left == 1) begin
      m_left <= 0; m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_dbz <= p_dbz;
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("stall_req", 64'(stall_req), 64'((m_left != 0) | (start & ~flush)));
      chk("done", 64'(done), 64'(m_done));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ez);
    int nbusy = 0;
    bit seen  = 1'b0;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
        chk({nm, "_dbz"}, 64'(div_by_zero), 64'(ez));
        chk({nm, "_busy_in_done"}, 64'(busy), 64'(0));
      end else if (busy) begin
        nbusy++;
      end
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'(1));
    chk({nm, "_busy_cycles"}, 64'(nbusy), 64'(W + 1));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; src_a = '0; src_b = '0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    tick();

    run_op("mult_7_m3",   2'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("multu_max",   2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("div_m7_2",    2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_7_m2",    2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf",     2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu_by0",    2'd3, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1);
    run_op("div_neg_by0", 2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_op("divu_big",    2'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0);
    // mthi alongside an accepted start must be dropped
    hi_we = 1'b1; wdata = 32'hDEAD;
    run_op("mult_we_drop", 2'd0, 32'hFFFFFFFE, 32'hFFFFFFFA, 32'h00000000, 32'h0000000C, 1'b0);

    hi_we = 1'b1; wdata = 32'h1234; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678; tick();
    lo_we = 1'b0;
    start = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd4; tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (i == 4) begin
        start = 1'b1; op = 2'd3; src_a = 32'd9; src_b = 32'd3;
        lo_we = 1'b1; wdata = 32'hBAD;
      end else begin
        start = 1'b0; lo_we = 1'b0;
      end
      tick();
    end
    start = 1'b0; lo_we = 1'b0;
    flush = 1'b1; tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_hi", 64'(hi), 64'(32'h1234));
    chk("flush_lo", 64'(lo), 64'(32'h5678));
    tick();
    for (int i = 0; i < 40; i++) tick();
    chk("flush_hi_later", 64'(hi), 64'(32'h1234));

    start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd7; tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_hi", 64'(hi), 64'(0));
    chk("rst_mid_lo", 64'(lo), 64'(0));
    chk("rst_mid_done", 64'(done), 64'(0));
    tick();
    for (int i = 0; i < 40; i++) tick();

    start = 1'b1; flush = 1'b1; op = 2'd0; src_a = 32'd5; src_b = 32'd5; tick();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start_flush_busy", 64'(busy), 64'(0));
    tick(); tick();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
